// File: rtl/bist_pkg.sv
// Shared BIST definitions: state encoding and default widths used by the
// sequencer, the comparator and the pattern/expected-data buffers.
package bist_pkg;

    localparam int BIST_DATA_W = 4;
    localparam int BIST_ADDR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/bist_settle_timer.sv
// Loadable down-counter that times how long a vector is held before sampling.
// Stops at zero; zero_o is decoded from the counter register.
module bist_settle_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bist_sequencer.sv
// BIST vector sequencer: steps vec_addr, waits for settling, samples
// Error_flag once per vector and accumulates count/first-fail/verdict.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int NUM_VECTORS   = 16,
    parameter int ADDR_W        = BIST_ADDR_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              Error_flag,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              apply,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_addr
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_VECTORS - 1);
    localparam logic [ADDR_W:0]   ERR_MAX     = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   err_q, err_d;
    logic              ffv_q, ffv_d;
    logic [ADDR_W-1:0] ffa_q, ffa_d;
    logic              apply_q, apply_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              tmr_load, tmr_dec, tmr_zero;
    logic              running;

    bist_settle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign running = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                     (state_q == S_SAMPLE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffa_d    = ffa_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        if (abort && running) begin
            // Abandon the run; partial results stay visible until next start
            state_d = S_IDLE;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err_d   = '0;
                        ffv_d   = 1'b0;
                        ffa_d   = '0;
                        addr_d  = '0;
                        state_d = S_APPLY;
                    end
                end
                S_APPLY: begin
                    tmr_load = 1'b1;
                    state_d  = S_SETTLE;
                end
                S_SETTLE: begin
                    if (tmr_zero) begin
                        state_d = S_SAMPLE;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (Error_flag) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffa_d = addr_q;
                        end
                    end
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_APPLY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state
    always_comb begin
        apply_d = (state_d == S_APPLY);
        busy_d  = (state_d == S_APPLY) || (state_d == S_SETTLE) ||
                  (state_d == S_SAMPLE);
        done_d  = (state_d == S_DONE);
        pass_d  = (state_d == S_DONE) && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffa_q   <= '0;
            apply_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffa_q   <= ffa_d;
            apply_q <= apply_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_addr         = addr_q;
    assign apply            = apply_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_addr  = ffa_q;

endmodule
